// File: rtl/three_to_eight_decoder_seq.sv
// Sequenced 3-to-8 decoder: accepts a code on valid/ready, drives its one-hot line
// for HOLD_CYCLES, then holds all lines low for GAP_CYCLES. Optional macro: DECODER_ILLEGAL_CODE_EN.
module three_to_eight_decoder_seq #(
    parameter int CODE_W      = 3,
    parameter int OUT_W       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [OUT_W-1:0]  dout,
    output logic              busy,
    output logic              done
`ifdef DECODER_ILLEGAL_CODE_EN
   ,output logic              err
`endif
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic [OUT_W-1:0]   code_onehot;
    logic               accept;
    logic               start_seq;

    // Codes at or above OUT_W decode to all-zero, which also marks them illegal.
    always_comb begin
        code_onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (din == CODE_W'(i)) code_onehot[i] = 1'b1;
        end
    end

    assign accept = din_valid && din_ready;

`ifdef DECODER_ILLEGAL_CODE_EN
    logic err_q, err_d;

    assign start_seq = accept && (|code_onehot);
    assign err_d     = err_q | (accept && !(|code_onehot));
    assign err       = err_q;
`else
    assign start_seq = accept;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_seq) begin
                    state_d = ST_DRIVE;
                    cnt_d   = HOLD_LOAD;
                    dout_d  = code_onehot;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    dout_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                dout_d = '0;
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                dout_d  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

`ifdef DECODER_ILLEGAL_CODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`endif

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign dout      = dout_q;
    // The final cycle is the last GAP cycle, or the last DRIVE cycle when there is no gap.
    assign done      = (cnt_q == '0) &&
                       ((state_q == ST_GAP) || ((GAP_CYCLES == 0) && (state_q == ST_DRIVE)));

endmodule

// File: tb/tb_three_to_eight_decoder_seq.sv
// Directed bench for three_to_eight_decoder_seq: default, HOLD=1/GAP=0 and OUT_W=6 builds.
module tb_three_to_eight_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [2:0] din_a = '0, din_b = '0, din_c = '0;
    logic       vld_a = 1'b0, vld_b = 1'b0, vld_c = 1'b0;
    logic       rdy_a, rdy_b, rdy_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [7:0] dout_a, dout_b;
    logic [5:0] dout_c;
`ifdef DECODER_ILLEGAL_CODE_EN
    logic       err_a, err_b, err_c;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    three_to_eight_decoder_seq u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
        .dout(dout_a), .busy(busy_a), .done(done_a)
`ifdef DECODER_ILLEGAL_CODE_EN
       ,.err(err_a)
`endif
    );

    three_to_eight_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
        .dout(dout_b), .busy(busy_b), .done(done_b)
`ifdef DECODER_ILLEGAL_CODE_EN
       ,.err(err_b)
`endif
    );

    three_to_eight_decoder_seq #(.OUT_W(6)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .din(din_c), .din_valid(vld_c), .din_ready(rdy_c),
        .dout(dout_c), .busy(busy_c), .done(done_c)
`ifdef DECODER_ILLEGAL_CODE_EN
       ,.err(err_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_a", 32'(dout_a), 32'h00);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_rdy_a",  32'(rdy_a),  32'd1);
        check("rst_rdy_b",  32'(rdy_b),  32'd1);
        check("rst_dout_c", 32'(dout_c), 32'h00);
        rst_n = 1'b1;
        tick();

        // Single code 5: one-hot for cycles 1-4, gap with done at 5, ready at 6
        din_a = 3'd5; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        check("c1_rdy", 32'(rdy_a), 32'd0);
        check("c1_busy", 32'(busy_a), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            check($sformatf("hold_dout_c%0d", c), 32'(dout_a), 32'h20);
            check($sformatf("hold_done_c%0d", c), 32'(done_a), 32'd0);
        end
        tick();
        check("gap_dout", 32'(dout_a), 32'h00);
        check("gap_done", 32'(done_a), 32'd1);
        check("gap_busy", 32'(busy_a), 32'd1);
        tick();
        check("idle_rdy",  32'(rdy_a),  32'd1);
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_done", 32'(done_a), 32'd0);

        // Sweep 0..7 with valid held; accepts fall every 6 cycles
        din_a = 3'd0; vld_a = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] exp_oh;
            exp_oh = 8'h01 << k;
            check($sformatf("sweep%0d_c1", k), 32'(dout_a), 32'(exp_oh));
            if (k < 7) din_a = 3'(k + 1);
            else       vld_a = 1'b0;
            for (int c = 2; c <= 4; c++) begin
                tick();
                check($sformatf("sweep%0d_c%0d", k, c), 32'(dout_a), 32'(exp_oh));
                check($sformatf("sweep%0d_onehot", k), 32'($countones(dout_a) <= 1), 32'd1);
            end
            tick();
            check($sformatf("sweep%0d_gap", k), 32'(dout_a), 32'h00);
            check($sformatf("sweep%0d_done", k), 32'(done_a), 32'd1);
            tick();
            check($sformatf("sweep%0d_rdy", k), 32'(rdy_a), 32'd1);
            check($sformatf("sweep%0d_idle_dout", k), 32'(dout_a), 32'h00);
            tick();
        end
        check("sweep_end_busy", 32'(busy_a), 32'd0);

        // Valid pulse while busy must be dropped
        din_a = 3'd3; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        tick();
        din_a = 3'd2; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        check("drop_c3", 32'(dout_a), 32'h08);
        tick();
        check("drop_c4", 32'(dout_a), 32'h08);
        tick();
        check("drop_gap_done", 32'(done_a), 32'd1);
        tick();
        check("drop_idle", 32'(rdy_a), 32'd1);
        tick();
        check("drop_no_seq_busy", 32'(busy_a), 32'd0);
        check("drop_no_seq_dout", 32'(dout_a), 32'h00);

        // HOLD=1, GAP=0: one cycle of 0x80 with done; re-accept 2 cycles later
        din_b = 3'd7; vld_b = 1'b1;
        tick();
        check("b_c1_dout", 32'(dout_b), 32'h80);
        check("b_c1_done", 32'(done_b), 32'd1);
        check("b_c1_busy", 32'(busy_b), 32'd1);
        tick();
        check("b_c2_dout", 32'(dout_b), 32'h00);
        check("b_c2_rdy",  32'(rdy_b),  32'd1);
        check("b_c2_done", 32'(done_b), 32'd0);
        tick();
        vld_b = 1'b0;
        check("b_c3_dout", 32'(dout_b), 32'h80);
        tick();
        check("b_c4_idle", 32'(busy_b), 32'd0);

        // OUT_W=6: code 5 is the top line, code 6 is out of range
        din_c = 3'd5; vld_c = 1'b1;
        tick();
        vld_c = 1'b0;
        check("c_code5", 32'(dout_c), 32'h20);
        repeat (5) tick();
        check("c_code5_idle", 32'(rdy_c), 32'd1);
        din_c = 3'd6; vld_c = 1'b1;
        tick();
        vld_c = 1'b0;
        check("c_ill_dout", 32'(dout_c), 32'h00);
`ifdef DECODER_ILLEGAL_CODE_EN
        check("c_ill_err",  32'(err_c),  32'd1);
        check("c_ill_busy", 32'(busy_c), 32'd0);
        repeat (3) tick();
        check("c_err_sticky", 32'(err_c), 32'd1);
        check("c_ill_dout2", 32'(dout_c), 32'h00);
`else
        check("c_ill_busy", 32'(busy_c), 32'd1);
        repeat (3) tick();
        check("c_ill_hold_dout", 32'(dout_c), 32'h00);
        tick();
        check("c_ill_done", 32'(done_c), 32'd1);
        tick();
        check("c_ill_idle", 32'(rdy_c), 32'd1);
`endif

        // Asynchronous reset in the middle of DRIVE
        din_a = 3'd5; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        tick();
        check("mid_drive_dout", 32'(dout_a), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout_a), 32'h00);
        check("async_rst_busy", 32'(busy_a), 32'd0);
        check("async_rst_rdy",  32'(rdy_a),  32'd1);
        check("async_rst_done", 32'(done_a), 32'd0);
`ifdef DECODER_ILLEGAL_CODE_EN
        check("async_rst_err", 32'(err_c), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy_a), 32'd0);
        check("post_rst_dout", 32'(dout_a), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
